// File: rtl/sargantana_icache_pkg.sv
// Shared types and constants for the icache refill responder.
// Line, beat and address widths here are the defaults the responder is built with.
package sargantana_icache_pkg;

   localparam int ICACHE_LINE_WIDTH   = 512;
   localparam int ICACHE_BEAT_WIDTH   = 128;
   localparam int ICACHE_PADDR_WIDTH  = 40;
   localparam int ICACHE_REFILL_BEATS = ICACHE_LINE_WIDTH / ICACHE_BEAT_WIDTH;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      COLLECT = 3'd2,
      RESP    = 3'd3,
      DRAIN   = 3'd4
   } refill_state_t;

   typedef struct packed {
      logic                          valid;
      logic [ICACHE_PADDR_WIDTH-1:0] paddr;
   } ifill_req_t;

   typedef struct packed {
      logic                         valid;
      logic [ICACHE_LINE_WIDTH-1:0] data;
      logic                         error;
   } ifill_resp_t;

endpackage

// File: rtl/sargantana_icache_line_asm.sv
// Beat-indexed line buffer: beats land in the slot picked by a wrapping counter.
// The counter also advances on drained beats so the FSM can spot the last one.
module sargantana_icache_line_asm
   import sargantana_icache_pkg::*;
#(
   parameter int LINE_WIDTH = ICACHE_LINE_WIDTH,
   parameter int BEAT_WIDTH = ICACHE_BEAT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  adv,
   input  logic                  wr_en,
   input  logic [BEAT_WIDTH-1:0] beat,
   output logic [LINE_WIDTH-1:0] line,
   output logic                  last
);

   localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [BEATS-1:0][BEAT_WIDTH-1:0] beat_mem;
   logic [CW-1:0]                    count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         beat_mem <= '0;
      end else if (clr) begin
         count    <= '0;
         beat_mem <= '0;
      end else begin
         if (adv) begin
            count <= count + 1'b1;
         end
         if (wr_en) begin
            beat_mem[count] <= beat;
         end
      end
   end

   assign line = beat_mem;
   assign last = (count == CW'(BEATS - 1));

endmodule

// File: rtl/sargantana_icache_refill_responder.sv
// Memory-side end of the icache ifill interface: one line read per miss, beats
// assembled into a line, single-cycle response; a kill drains the line silently.
module sargantana_icache_refill_responder
   import sargantana_icache_pkg::*;
#(
   parameter int LINE_WIDTH  = ICACHE_LINE_WIDTH,
   parameter int BEAT_WIDTH  = ICACHE_BEAT_WIDTH,
   parameter int PADDR_WIDTH = ICACHE_PADDR_WIDTH
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   ifill_req_valid_i,
   input  logic [PADDR_WIDTH-1:0] ifill_req_paddr_i,
   output logic                   ifill_req_ready_o,
   input  logic                   ifill_kill_i,
   output logic                   ifill_resp_valid_o,
   output logic [LINE_WIDTH-1:0]  ifill_resp_data_o,
   output logic                   ifill_resp_error_o,
   output logic                   mem_req_valid_o,
   output logic [PADDR_WIDTH-1:0] mem_req_addr_o,
   input  logic                   mem_req_ready_i,
   input  logic                   mem_resp_valid_i,
   input  logic [BEAT_WIDTH-1:0]  mem_resp_data_i,
   input  logic                   mem_resp_error_i
);

   localparam int OFF = $clog2(LINE_WIDTH / 8);

   refill_state_t          state, next_state;
   ifill_req_t             req;
   ifill_resp_t            resp;
   logic [PADDR_WIDTH-1:0] addr_q;
   logic                   mem_req_valid_q;
   logic                   err_q;
   logic [LINE_WIDTH-1:0]  hold_data;
   logic                   hold_err;
   logic                   accept;
   logic                   beat_in;
   logic [LINE_WIDTH-1:0]  line;
   logic                   last;
   logic                   unused_paddr_bits;

   assign req.valid = ifill_req_valid_i;
   assign req.paddr = ifill_req_paddr_i;
   assign unused_paddr_bits = ^req.paddr[OFF-1:0];

   // Handshakes: a transfer happens on any rising edge where valid and ready are
   // both high; the ifill request additionally loses to a kill in the same cycle.
   assign accept  = (state == IDLE) && req.valid && !ifill_kill_i;
   assign beat_in = mem_resp_valid_i && ((state == COLLECT) || (state == DRAIN));

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) next_state = REQ;
         end
         REQ: begin
            if (mem_req_ready_i) next_state = ifill_kill_i ? DRAIN : COLLECT;
            else if (ifill_kill_i) next_state = IDLE;
         end
         COLLECT: begin
            // A kill landing on the final beat has nothing left to drain.
            if (mem_resp_valid_i && last) next_state = ifill_kill_i ? IDLE : RESP;
            else if (ifill_kill_i) next_state = DRAIN;
         end
         RESP: begin
            next_state = IDLE;
         end
         DRAIN: begin
            if (mem_resp_valid_i && last) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state           <= IDLE;
         addr_q          <= '0;
         mem_req_valid_q <= 1'b0;
         err_q           <= 1'b0;
         hold_data       <= '0;
         hold_err        <= 1'b0;
      end else begin
         state           <= next_state;
         mem_req_valid_q <= (next_state == REQ);
         if (accept) begin
            addr_q <= {req.paddr[PADDR_WIDTH-1:OFF], {OFF{1'b0}}};
            err_q  <= 1'b0;
         end else if ((state == COLLECT) && mem_resp_valid_i) begin
            err_q <= err_q | mem_resp_error_i;
         end
         // Outside RESP the outputs replay the last line actually delivered.
         if ((state == RESP) && !ifill_kill_i) begin
            hold_data <= line;
            hold_err  <= err_q;
         end
      end
   end

   sargantana_icache_line_asm #(
      .LINE_WIDTH (LINE_WIDTH),
      .BEAT_WIDTH (BEAT_WIDTH)
   ) u_line_asm (
      .clk   (clk_i),
      .rst_n (rstn_i),
      .clr   (accept),
      .adv   (beat_in),
      .wr_en (beat_in && (state == COLLECT)),
      .beat  (mem_resp_data_i),
      .line  (line),
      .last  (last)
   );

   assign resp.valid = (state == RESP) && !ifill_kill_i;
   assign resp.data  = (state == RESP) ? line  : hold_data;
   assign resp.error = (state == RESP) ? err_q : hold_err;

   assign ifill_req_ready_o  = (state == IDLE);
   assign ifill_resp_valid_o = resp.valid;
   assign ifill_resp_data_o  = resp.data;
   assign ifill_resp_error_o = resp.error;
   assign mem_req_valid_o    = mem_req_valid_q;
   assign mem_req_addr_o     = addr_q;

   resp_outside_window: assert property (@(posedge clk_i) disable iff (!rstn_i)
      mem_resp_valid_i |-> ((state == COLLECT) || (state == DRAIN)));

endmodule

// File: tb/tb_sargantana_icache_refill_responder.sv
// Bench for the icache refill responder: directed corner cases then randomized
// lines, scored against a line-level model of the refill protocol.
module tb_sargantana_icache_refill_responder;

   logic         clk;
   logic         rstn;
   logic         ifill_req_valid;
   logic [39:0]  ifill_req_paddr;
   logic         ready;
   logic         ifill_kill;
   logic         resp_valid;
   logic [511:0] resp_data;
   logic         resp_error;
   logic         mem_req_valid;
   logic [39:0]  mem_req_addr;
   logic         mem_req_ready;
   logic         mem_resp_valid;
   logic [127:0] mem_resp_data;
   logic         mem_resp_error;

   int           n_vec;
   int           n_err;
   int           hs_cnt;
   int           exp_hs;
   logic [39:0]  exp_addr;
   logic [512:0] exp_q[$];

   sargantana_icache_refill_responder dut (
      .clk_i              (clk),
      .rstn_i             (rstn),
      .ifill_req_valid_i  (ifill_req_valid),
      .ifill_req_paddr_i  (ifill_req_paddr),
      .ifill_req_ready_o  (ready),
      .ifill_kill_i       (ifill_kill),
      .ifill_resp_valid_o (resp_valid),
      .ifill_resp_data_o  (resp_data),
      .ifill_resp_error_o (resp_error),
      .mem_req_valid_o    (mem_req_valid),
      .mem_req_addr_o     (mem_req_addr),
      .mem_req_ready_i    (mem_req_ready),
      .mem_resp_valid_i   (mem_resp_valid),
      .mem_resp_data_i    (mem_resp_data),
      .mem_resp_error_i   (mem_resp_error)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // scoreboard: responses and memory request handshakes
   always @(negedge clk) begin
      logic [512:0] e;
      if (rstn && resp_valid) begin
         if (exp_q.size() == 0) begin
            check_eq("resp_unexpected", resp_valid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check_eq("resp_data", resp_data, e[511:0]);
            check_eq("resp_error", resp_error, e[512]);
         end
      end
      if (rstn && mem_req_valid && mem_req_ready) begin
         hs_cnt++;
         check_eq("hs_addr", mem_req_addr, exp_addr);
      end
   end

   function automatic logic [39:0] rand_addr();
      logic [39:0] a;
      a = {8'($urandom), 32'($urandom)};
      return a;
   endfunction

   // Kill codes: -1 none, 0 with accept, 1 in REQ before handshake, 2 with handshake,
   // 3+k idle cycle before beat k, 7+k with beat k, 11 during the response cycle.
   task automatic run_line(input logic [39:0] paddr, input int bp, input int kcode,
                           input int err_beat, input bit pat);
      logic [511:0] line;
      logic [127:0] d;
      logic [3:0]   nib;
      logic         err;
      bit           killed;
      bit           delivered;
      int           gaps;
      line   = '0;
      err    = 1'b0;
      killed = 1'b0;
      ifill_req_valid = 1'b1;
      ifill_req_paddr = paddr;
      ifill_kill      = (kcode == 0);
      @(negedge clk);
      check_eq("ready_idle", ready, 1'b1);
      @(posedge clk); #1;
      ifill_req_valid = 1'b0;
      ifill_kill      = 1'b0;
      if (kcode == 0) begin
         @(negedge clk);
         check_eq("kill_accept_ready", ready, 1'b1);
         check_eq("kill_accept_memreq", mem_req_valid, 1'b0);
         @(posedge clk); #1;
         return;
      end
      exp_addr = paddr - (paddr % 40'd64);
      for (int i = 0; i < bp; i++) begin
         mem_req_ready = 1'b0;
         @(negedge clk);
         check_eq("req_valid_hold", mem_req_valid, 1'b1);
         check_eq("req_addr_hold", mem_req_addr, exp_addr);
         @(posedge clk); #1;
      end
      if (kcode == 1) begin
         ifill_kill = 1'b1;
         @(posedge clk); #1;
         ifill_kill = 1'b0;
         @(negedge clk);
         check_eq("req_kill_valid", mem_req_valid, 1'b0);
         check_eq("req_kill_ready", ready, 1'b1);
         @(posedge clk); #1;
         return;
      end
      mem_req_ready = 1'b1;
      ifill_kill    = (kcode == 2);
      exp_hs++;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      ifill_kill    = 1'b0;
      killed        = (kcode == 2);
      for (int k = 0; k < 4; k++) begin
         gaps = $urandom_range(0, 2);
         if (kcode == 3 + k && gaps == 0) gaps = 1;
         for (int g = 0; g < gaps; g++) begin
            ifill_kill = (kcode == 3 + k && g == 0) || (killed && $urandom_range(0, 1) == 1);
            if (kcode == 3 + k && g == 0) killed = 1'b1;
            @(posedge clk); #1;
            ifill_kill = 1'b0;
         end
         nib = 4'hA + 4'(k);
         d   = pat ? {32{nib}} : {$urandom, $urandom, $urandom, $urandom};
         mem_resp_valid = 1'b1;
         mem_resp_data  = d;
         mem_resp_error = (k == err_beat);
         ifill_kill     = (kcode == 7 + k) || (killed && $urandom_range(0, 1) == 1);
         line[k*128 +: 128] = d;
         err = err | (k == err_beat);
         if (kcode == 7 + k) killed = 1'b1;
         @(posedge clk); #1;
         mem_resp_valid = 1'b0;
         mem_resp_error = 1'b0;
         ifill_kill     = 1'b0;
      end
      delivered = !killed && (kcode != 11);
      if (delivered) exp_q.push_back({err, line});
      ifill_kill = !killed && (kcode == 11);
      @(negedge clk);
      check_eq("resp_valid_timing", resp_valid, delivered);
      @(posedge clk); #1;
      ifill_kill = 1'b0;
      @(negedge clk);
      check_eq("ready_after_line", ready, 1'b1);
      check_eq("resp_valid_one_cycle", resp_valid, 1'b0);
      if (delivered) begin
         check_eq("hold_data", resp_data, line);
         check_eq("hold_error", resp_error, err);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      n_vec = 0; n_err = 0; hs_cnt = 0; exp_hs = 0; exp_addr = '0;
      rstn = 1'b0;
      ifill_req_valid = 1'b0; ifill_req_paddr = '0; ifill_kill = 1'b0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_error = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_ready", ready, 1'b1);
      check_eq("rst_resp_valid", resp_valid, 1'b0);
      check_eq("rst_resp_data", resp_data, '0);
      check_eq("rst_resp_error", resp_error, 1'b0);
      check_eq("rst_memreq_valid", mem_req_valid, 1'b0);
      check_eq("rst_memreq_addr", mem_req_addr, '0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;

      // kill while idle is ignored
      ifill_kill = 1'b1;
      @(posedge clk); #1;
      ifill_kill = 1'b0;
      @(negedge clk);
      check_eq("idle_kill_ready", ready, 1'b1);
      check_eq("idle_kill_memreq", mem_req_valid, 1'b0);
      @(posedge clk); #1;

      run_line(40'h00_8000_1234, 0, -1, -1, 1'b1);
      check_eq("directed_addr", exp_addr, 40'h00_8000_1200);
      run_line(rand_addr(), 5, -1, -1, 1'b0);
      run_line(rand_addr(), 0, -1, 2, 1'b0);
      run_line(rand_addr(), 0, -1, -1, 1'b0);
      run_line(rand_addr(), 1, 5, -1, 1'b0);
      run_line(rand_addr(), 2, 1, -1, 1'b0);
      run_line(rand_addr(), 0, 11, -1, 1'b0);
      run_line(rand_addr(), 0, 0, -1, 1'b0);
      run_line(rand_addr(), 0, 2, -1, 1'b0);
      run_line(rand_addr(), 0, 8, 1, 1'b0);
      run_line(rand_addr(), 0, 10, -1, 1'b0);
      run_line(rand_addr(), 0, -1, 3, 1'b0);

      // reset in the middle of a refill
      ifill_req_valid = 1'b1;
      ifill_req_paddr = rand_addr();
      @(posedge clk); #1;
      ifill_req_valid = 1'b0;
      exp_addr = ifill_req_paddr - (ifill_req_paddr % 40'd64);
      mem_req_ready = 1'b1;
      exp_hs++;
      @(posedge clk); #1;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      rstn = 1'b0;
      @(negedge clk);
      check_eq("midrst_ready", ready, 1'b1);
      check_eq("midrst_memreq", mem_req_valid, 1'b0);
      check_eq("midrst_resp_valid", resp_valid, 1'b0);
      check_eq("midrst_resp_data", resp_data, '0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;

      for (int n = 0; n < 40; n++) begin
         int kc;
         kc = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 11) : -1;
         run_line(rand_addr(), $urandom_range(0, 3), kc, $urandom_range(0, 4) - 1, 1'b0);
      end

      repeat (3) @(posedge clk);
      check_eq("exp_q_drained", exp_q.size(), 0);
      check_eq("hs_count", hs_cnt, exp_hs);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
